// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    // ADDI x0,x0,0 shown whenever the output slot is empty
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction addresses are word aligned; low two bits are dropped
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register that catches a response arriving while the
// output slot is stalled. Clear wins over load, load wins over drain.
module fetch_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // Next-state selection for the skid entry
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            instr_d = load_instr;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // Skid storage with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit with a registered
// output slot, a one-entry skid buffer and redirect/kill handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = fetch_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    import fetch_pkg::fetch_state_t;
    import fetch_pkg::ST_IDLE;
    import fetch_pkg::ST_REQ;
    import fetch_pkg::ST_WAIT;
    import fetch_pkg::ST_HOLD;
    import fetch_pkg::align_pc;

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pending_pc_q, pending_pc_d;
    logic         kill_q, kill_d;
    logic         slot_valid_q, slot_valid_d;
    logic [31:0]  slot_pc_q, slot_pc_d;
    logic [31:0]  slot_instr_q, slot_instr_d;

    logic         consume;
    logic         flush;
    logic         skid_load;
    logic         skid_drain;
    logic         skid_valid;
    logic [31:0]  skid_pc;
    logic [31:0]  skid_instr;

    // The slot is consumed whenever it holds an instruction and IF/ID accepts it
    assign consume = slot_valid_q && !stall;

    fetch_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (flush),
        .load_pc    (pending_pc_q),
        .load_instr (imem_rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    // FSM next state, fetch PC update, slot/skid steering and redirect flush
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        kill_d       = kill_q;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
        flush        = 1'b0;
        skid_load    = 1'b0;
        skid_drain   = 1'b0;

        if (consume) begin
            slot_valid_d = 1'b0;
            slot_pc_d    = 32'd0;
            slot_instr_d = NOP_INSTR;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = align_pc(redirect_pc);
                    if (imem_gnt) begin
                        // Granted request is in flight; its response must be dropped
                        pending_pc_d = fetch_pc_q;
                        kill_d       = 1'b1;
                        state_d      = ST_WAIT;
                    end
                end else if (imem_gnt) begin
                    pending_pc_d = fetch_pc_q;
                    fetch_pc_d   = fetch_pc_q + 32'd4;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = align_pc(redirect_pc);
                    if (imem_rvalid) begin
                        // Response arrives with the redirect: drop it, nothing outstanding
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else if (!slot_valid_q || consume) begin
                        slot_valid_d = 1'b1;
                        slot_pc_d    = pending_pc_q;
                        slot_instr_d = imem_rdata;
                        state_d      = ST_REQ;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = align_pc(redirect_pc);
                    state_d    = ST_REQ;
                end else if (consume) begin
                    slot_valid_d = skid_valid;
                    slot_pc_d    = skid_pc;
                    slot_instr_d = skid_instr;
                    skid_drain   = 1'b1;
                    state_d      = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            slot_valid_d = 1'b0;
            slot_pc_d    = 32'd0;
            slot_instr_d = NOP_INSTR;
        end
    end

    // State and output-slot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= 32'd0;
            kill_q       <= 1'b0;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= 32'd0;
            slot_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            kill_q       <= kill_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
        end
    end

    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = fetch_pc_q;
    assign valid_out = slot_valid_q;
    assign pc_out    = slot_pc_q;
    assign instr_out = slot_instr_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, instruction value shown when no valid instruction is held (ADDI x0,x0,0).
REQ-003 Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Port stall  in  1  downstream IF/ID hold; 1 = output not consumed this cycle.
REQ-006 Port redirect  in  1  branch/jump taken; highest priority.
REQ-007 Port redirect_pc  in  32  new fetch target; bits [1:0] SHALL be forced to 0.
REQ-008 Port imem_req  out  1  memory request.
REQ-009 Port imem_addr  out  32  request address.
REQ-010 Port imem_gnt  in  1  request accepted this cycle.
REQ-011 Port imem_rvalid  in  1  read data valid.
REQ-012 Port imem_rdata  in  32  instruction word.
REQ-013 Port pc_out  out  32  PC of the held instruction, registered.
REQ-014 Port instr_out  out  32  held instruction, registered.
REQ-015 Port valid_out  out  1  output slot holds a real instruction.

Function
REQ-016 States: IDLE, REQ, WAIT, HOLD; at most one outstanding memory request.
REQ-017 IDLE -> REQ unconditionally on the next cycle.
REQ-018 In REQ: imem_req=1 and imem_addr=fetch_pc; both stable until gnt unless redirect occurs.
REQ-019 REQ with gnt: pending_pc <= fetch_pc, fetch_pc <= fetch_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), then -> WAIT.
REQ-020 imem_req SHALL be 0 in IDLE, WAIT and HOLD; rvalid outside WAIT SHALL be ignored.
REQ-021 Slot consumption: the output slot is consumed in any cycle with valid_out=1 and stall=0.
REQ-022 WAIT with rvalid and kill=0: if the slot is empty or being consumed, load slot {pending_pc, rdata, valid=1} and -> REQ; otherwise write skid {pending_pc, rdata} and -> HOLD.
REQ-023 HOLD: when the slot is consumed, move skid into slot (valid=1), clear skid and -> REQ.
REQ-024 Fetch latency: data in slot on the cycle after rvalid; back-to-back throughput is 1 instruction per 2 cycles when gnt and rvalid are each single-cycle.
REQ-025 Slot-empty presentation: when valid_out=0, pc_out=0 and instr_out=NOP_INSTR.
REQ-026 Redirect (any state except IDLE) SHALL clear slot and skid, and set fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-027 Redirect in REQ without gnt aborts the request; the next cycle requests the new address.
REQ-028 Redirect in REQ with same-cycle gnt: the grant stands, kill <= 1, -> WAIT.
REQ-029 Redirect in WAIT without rvalid: kill <= 1, stay WAIT.
REQ-030 Redirect in WAIT with same-cycle rvalid: data dropped, kill stays 0, -> REQ.
REQ-031 WAIT with rvalid and kill=1: data dropped, kill <= 0, -> REQ.
REQ-032 Redirect in HOLD: -> REQ.
REQ-033 Priority: redirect over stall; stall over rvalid-to-slot loading.

Reset
REQ-034 On rst: state=IDLE, fetch_pc=RESET_PC, pending_pc=0, kill=0, skid empty, valid_out=0, pc_out=0, instr_out=NOP_INSTR, imem_req=0.
REQ-035 Reset during WAIT SHALL abandon the outstanding response; a late rvalid is ignored per REQ-020.

Structure
REQ-036 Shared package fetch_pkg SHALL hold fetch_state_t, NOP_INSTR and the default RESET_PC.
REQ-037 The 1-entry skid register SHALL be a sub-module fetch_skid (load, drain, clear, valid); all other logic is inline.

Verification
REQ-038 Reset, gnt=1 always, rvalid one cycle after gnt, stall=0 -> addresses 0,4,8 requested; valid_out with pc_out 0,4,8 and matching rdata.
REQ-039 stall=1 held while two responses (pc 8,12) arrive -> slot keeps pc 8, skid holds pc 12, imem_req=0; releasing stall -> pc 8 then pc 12 presented.
REQ-040 Redirect to 32'h0000_0102 while in WAIT -> next rvalid discarded; next imem_addr=32'h0000_0100; valid_out=0 until that response returns.
REQ-041 Redirect, gnt and rvalid in the same cycles per REQ-028 and REQ-030 -> no stale instruction ever reaches valid_out.
REQ-042 RESET_PC=32'hFFFF_FFFC -> requests FFFF_FFFC then 0000_0000 (wrap).
REQ-043 rst asserted in WAIT with rvalid arriving the following cycle -> response ignored; first request after IDLE is RESET_PC.
